// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and flow controller beside the ID stage of the 5-stage MIPS pipeline.
// Hazard outputs are combinational on registered pipeline state; stall_cnt and
// fetch_timeout are registered.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             id_redirect,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic [4:0]       ex_wreg,
  input  logic             mem_memread,
  input  logic [4:0]       mem_wreg,
  input  logic             if_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             fetch_timeout
);

  // Wide enough to hold FETCH_TIMEOUT and still saturate above it.
  localparam int unsigned WAIT_W = $clog2(FETCH_TIMEOUT + 2);

  typedef enum logic {
    RUN        = 1'b0,
    FETCH_WAIT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              fetch_timeout_q, fetch_timeout_d;

  logic match_ex, match_mem, h_lu, h_br, stall;

  // Hazard detection: register 0 never creates a dependency.
  always_comb begin
    match_ex  = (ex_wreg != 5'd0) &&
                ((id_uses_rs && (ex_wreg == id_rs)) || (id_uses_rt && (ex_wreg == id_rt)));
    match_mem = (mem_wreg != 5'd0) &&
                ((id_uses_rs && (mem_wreg == id_rs)) || (id_uses_rt && (mem_wreg == id_rt)));
    h_lu      = ex_memread && match_ex;
    h_br      = id_is_branch && ((ex_regwrite && match_ex) || (mem_memread && match_mem));
    stall     = h_lu || h_br;
  end

  // Flow-control outputs and next state, in priority reset > stall > redirect > fetch wait.
  always_comb begin
    pc_write        = 1'b1;
    if_id_write     = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    stall_cnt_d     = stall_cnt_q;
    fetch_timeout_d = fetch_timeout_q;

    if (reset) begin
      pc_write        = 1'b0;
      if_id_write     = 1'b0;
      if_id_flush     = 1'b1;
      id_ex_flush     = 1'b1;
      state_d         = RUN;
      wait_cnt_d      = '0;
      stall_cnt_d     = '0;
      fetch_timeout_d = 1'b0;
    end else if (stall) begin
      // Hold the ID instruction and bubble EX; fetch tracking is frozen.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      if (stall_cnt_q != '1) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end else if (id_redirect) begin
      // Squash the fall-through slot and drop any in-flight fetch.
      if_id_flush = 1'b1;
      state_d     = RUN;
      wait_cnt_d  = '0;
    end else begin
      if (!if_ready) begin
        pc_write    = 1'b0;
        if_id_flush = 1'b1;
      end
      case (state_q)
        RUN: begin
          if (!if_ready) begin
            state_d    = FETCH_WAIT;
            wait_cnt_d = WAIT_W'(1);
          end
        end
        FETCH_WAIT: begin
          if (if_ready) begin
            state_d    = RUN;
            wait_cnt_d = '0;
          end else begin
            if (wait_cnt_q == WAIT_W'(FETCH_TIMEOUT)) begin
              fetch_timeout_d = 1'b1;
            end
            if (wait_cnt_q != '1) begin
              wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
          end
        end
        default: begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      endcase
    end
  end

  // State registers; the synchronous reset is folded into the next-state logic.
  always_ff @(posedge clk) begin
    state_q         <= state_d;
    wait_cnt_q      <= wait_cnt_d;
    stall_cnt_q     <= stall_cnt_d;
    fetch_timeout_q <= fetch_timeout_d;
  end

  assign stall_cnt     = stall_cnt_q;
  assign fetch_timeout = fetch_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a narrow-counter instance covers saturation.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_wreg, mem_wreg;
  logic        id_uses_rs, id_uses_rt, id_is_branch, id_redirect;
  logic        ex_memread, ex_regwrite, mem_memread, if_ready;
  logic        pc_write, if_id_write, if_id_flush, id_ex_flush, fetch_timeout;
  logic [15:0] stall_cnt;
  logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_flush, s_fetch_timeout;
  logic [2:0]  s_stall_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch),
    .id_redirect(id_redirect), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
    .ex_wreg(ex_wreg), .mem_memread(mem_memread), .mem_wreg(mem_wreg),
    .if_ready(if_ready), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .stall_cnt(stall_cnt),
    .fetch_timeout(fetch_timeout)
  );

  pipeline_hazard_ctrl #(.CNT_W(3), .FETCH_TIMEOUT(15)) dut_sat (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch),
    .id_redirect(id_redirect), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
    .ex_wreg(ex_wreg), .mem_memread(mem_memread), .mem_wreg(mem_wreg),
    .if_ready(if_ready), .pc_write(s_pc_write), .if_id_write(s_if_id_write),
    .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush), .stall_cnt(s_stall_cnt),
    .fetch_timeout(s_fetch_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected is {pc_write, if_id_write, if_id_flush, id_ex_flush}.
  task automatic chk_out(input string tag, input logic [3:0] exp);
    #1;
    chk(tag, {28'd0, pc_write, if_id_write, if_id_flush, id_ex_flush}, {28'd0, exp});
  endtask

  task automatic clear_in();
    reset = 1'b0; id_rs = 5'd0; id_rt = 5'd0; ex_wreg = 5'd0; mem_wreg = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_is_branch = 1'b0; id_redirect = 1'b0;
    ex_memread = 1'b0; ex_regwrite = 1'b0; mem_memread = 1'b0; if_ready = 1'b1;
  endtask

  task automatic run_wait(input int n);
    if_ready = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    clear_in();
  endtask

  initial begin
    clear_in();
    reset = 1'b1;
    chk_out("reset_row", 4'b0011);
    tick();
    tick();
    chk("reset_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_timeout", 32'(fetch_timeout), 32'd0);
    reset = 1'b0;
    chk_out("normal", 4'b1100);

    // Load-use on rs
    ex_memread = 1'b1; ex_wreg = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    chk_out("lu_rs", 4'b0001);
    tick();
    chk("lu_cnt", 32'(stall_cnt), 32'd1);
    clear_in();
    chk_out("lu_release", 4'b1100);

    // Register 0 never hazards
    ex_memread = 1'b1; ex_wreg = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    chk_out("lu_r0", 4'b1100);
    tick();
    chk("lu_r0_cnt", 32'(stall_cnt), 32'd1);

    // Load-use on rt, only when rt is actually read
    clear_in();
    ex_memread = 1'b1; ex_wreg = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1;
    chk_out("lu_rt", 4'b0001);
    tick();
    chk("lu_rt_cnt", 32'(stall_cnt), 32'd2);
    id_uses_rt = 1'b0;
    chk_out("lu_rt_unused", 4'b1100);
    id_uses_rt = 1'b1; ex_wreg = 5'd6;
    chk_out("lu_rt_other", 4'b1100);

    // Branch after load: EX stall then MEM stall
    clear_in();
    id_is_branch = 1'b1; id_rt = 5'd9; id_uses_rt = 1'b1;
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd9;
    chk_out("br_load_ex", 4'b0001);
    tick();
    chk("br_load_cnt1", 32'(stall_cnt), 32'd3);
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_wreg = 5'd0;
    mem_memread = 1'b1; mem_wreg = 5'd9;
    chk_out("br_load_mem", 4'b0001);
    tick();
    chk("br_load_cnt2", 32'(stall_cnt), 32'd4);
    mem_memread = 1'b0;
    chk_out("br_load_issue", 4'b1100);
    tick();
    chk("br_load_cnt3", 32'(stall_cnt), 32'd4);

    // Branch after ALU op: one stall; same producer with a non-branch does not stall
    ex_regwrite = 1'b1; ex_wreg = 5'd9;
    chk_out("br_alu", 4'b0001);
    tick();
    chk("br_alu_cnt", 32'(stall_cnt), 32'd5);
    id_is_branch = 1'b0;
    chk_out("alu_nonbranch", 4'b1100);

    // Redirect squash, and stall overriding redirect
    clear_in();
    id_redirect = 1'b1;
    chk_out("redirect", 4'b1110);
    ex_memread = 1'b1; ex_wreg = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    chk_out("redirect_vs_lu", 4'b0001);
    tick();
    chk("redirect_lu_cnt", 32'(stall_cnt), 32'd6);

    // Fetch wait for 16 cycles: timeout sets after the 16th edge
    clear_in();
    if_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk_out($sformatf("fwait_out_%0d", i), 4'b0110);
      chk($sformatf("fwait_to_%0d", i), 32'(fetch_timeout), 32'd0);
      tick();
    end
    chk("timeout_set", 32'(fetch_timeout), 32'd1);
    if_ready = 1'b1;
    chk_out("fetch_resume", 4'b1100);
    tick();
    tick();
    chk("timeout_sticky", 32'(fetch_timeout), 32'd1);

    // Reset during the second branch stall
    clear_in();
    id_is_branch = 1'b1; id_rt = 5'd9; id_uses_rt = 1'b1;
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd9;
    tick();
    ex_memread = 1'b0; ex_regwrite = 1'b0; mem_memread = 1'b1; mem_wreg = 5'd9;
    reset = 1'b1;
    chk_out("reset_mid_stall", 4'b0011);
    tick();
    clear_in();
    chk("post_reset_cnt", 32'(stall_cnt), 32'd0);
    chk("post_reset_to", 32'(fetch_timeout), 32'd0);
    chk_out("post_reset_out", 4'b1100);

    // if_ready=1 restarts the wait count
    run_wait(10);
    if_ready = 1'b1;
    tick();
    run_wait(15);
    chk("ready_restart_15", 32'(fetch_timeout), 32'd0);
    tick();
    chk("ready_restart_16", 32'(fetch_timeout), 32'd1);
    do_reset();
    chk("reset_clears_to", 32'(fetch_timeout), 32'd0);

    // Redirect with if_ready=0 drops the fetch and restarts the count
    run_wait(10);
    id_redirect = 1'b1;
    chk_out("redirect_no_ready", 4'b1110);
    tick();
    id_redirect = 1'b0;
    run_wait(15);
    chk("redir_restart_15", 32'(fetch_timeout), 32'd0);
    tick();
    chk("redir_restart_16", 32'(fetch_timeout), 32'd1);
    do_reset();

    // Stall freezes the wait count
    run_wait(10);
    ex_memread = 1'b1; ex_wreg = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    chk_out("stall_in_wait", 4'b0001);
    repeat (3) tick();
    ex_memread = 1'b0;
    run_wait(5);
    chk("stall_hold_15", 32'(fetch_timeout), 32'd0);
    tick();
    chk("stall_hold_16", 32'(fetch_timeout), 32'd1);
    chk("stall_hold_cnt", 32'(stall_cnt), 32'd3);

    // Saturation of a narrow counter
    ex_memread = 1'b1;
    repeat (10) tick();
    chk("cnt_13", 32'(stall_cnt), 32'd13);
    chk("cnt_sat", 32'(s_stall_cnt), 32'd7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
